booth_mac_acc: RTL and testbench

- Downstream stage of the 16x16 signed Booth multiplier.
- Consumes its 32-bit signed products over a valid/ready handshake.
- Sums LEN consecutive products into a guarded signed accumulator, then presents the dot-product result over an output valid/ready handshake.
- Sits between the multiplier and the result-collection logic of the MAC datapath.

---
 rtl/booth_mac_acc_if.sv | 42 ++++
 rtl/booth_mac_acc.sv | 226 ++++++++++++++++++++++
 tb/tb_booth_mac_acc.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/booth_mac_acc_if.sv
// ---------------------------------------------------------------------------
// booth_mac_acc_if
// Product-in / result-out handshake bundle between the Booth multiplier,
// the MAC accumulator stage (booth_mac_acc) and the result collector.
//   master : the environment side (drives products, accepts results)
//   slave  : the accumulator side
// ---------------------------------------------------------------------------
interface booth_mac_acc_if #(
    parameter int PROD_W = 32,
    parameter int ACC_W  = 40
);
    // Product stream from the multiplier
    logic                     in_valid;
    logic                     in_ready;
    logic signed [PROD_W-1:0] in_prod;

    // Result stream to the collector
    logic                     out_valid;
    logic                     out_ready;
    logic signed [ACC_W-1:0]  out_sum;
    logic                     out_ovf;

    modport master (
        output in_valid,
        output in_prod,
        input  in_ready,
        input  out_valid,
        input  out_sum,
        input  out_ovf,
        output out_ready
    );

    modport slave (
        input  in_valid,
        input  in_prod,
        output in_ready,
        output out_valid,
        output out_sum,
        output out_ovf,
        input  out_ready
    );
endinterface

// File: rtl/booth_mac_acc.sv
// ---------------------------------------------------------------------------
// booth_mac_acc
// Accumulates LEN consecutive signed products from the Booth multiplier into
// an ACC_W-bit signed accumulator and hands the dot-product result onward.
//
//   ACC  : accept products; the LEN-th accept registers the result -> DONE
//   DONE : hold out_sum/out_ovf with out_valid until out_ready -> ACC
//
// out_ovf is a sticky flag covering every addition of the current sum.
// clr is a synchronous abort with priority over everything else; it also
// blocks in_ready in the same cycle so a presented product is dropped.
//
// Optional build macro: SATURATE_EN
//   undefined : two's-complement wrap modulo 2^ACC_W
//   defined   : an overflowing addition clamps the accumulator to the
//               positive or negative limit matching the addend signs
// ---------------------------------------------------------------------------
module booth_mac_acc #(
    parameter int PROD_W = 32,
    parameter int ACC_W  = 40,
    parameter int LEN    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    booth_mac_acc_if.slave    bus,
    output logic              busy
);

    // Counter width; a single-product sum still needs a 1-bit counter
    localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Saturation limits of the accumulator
    localparam logic signed [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] ACC_ZERO = {ACC_W{1'b0}};

    typedef enum logic [0:0] {
        ST_ACC  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    // -----------------------------------------------------------------------
    // Arithmetic helpers
    // -----------------------------------------------------------------------

    // Sign-extend a product to the accumulator width
    function automatic logic signed [ACC_W-1:0] sign_extend(
        input logic signed [PROD_W-1:0] p
    );
        return ACC_W'(p);
    endfunction

    // Signed addition overflow: operands agree in sign, result does not
    function automatic logic add_overflow(
        input logic a_msb,
        input logic b_msb,
        input logic s_msb
    );
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    state_t                  state_r;
    state_t                  state_next_s;
    logic signed [ACC_W-1:0] acc_r;
    logic [CNT_W-1:0]        cnt_r;
    logic                    ovf_r;
    logic signed [ACC_W-1:0] out_sum_r;
    logic                    out_ovf_r;
    logic                    busy_r;

    // Combinational datapath / control
    logic signed [ACC_W-1:0] prod_ext_s;
    logic signed [ACC_W-1:0] raw_sum_s;
    logic signed [ACC_W-1:0] sum_s;
    logic                    ovf_step_s;
    logic                    ovf_total_s;
    logic                    in_ready_s;
    logic                    out_valid_s;
    logic                    accept_s;
    logic                    last_s;
    logic                    consume_s;

    // Handshake qualifiers shared by the FSM and the datapath
    assign accept_s  = bus.in_valid && in_ready_s;
    assign last_s    = (cnt_r == CNT_LAST);
    assign consume_s = (state_r == ST_DONE) && bus.out_ready && !clr;

    // Adder with overflow detection and optional clamping
    always_comb begin
        prod_ext_s  = sign_extend(bus.in_prod);
        raw_sum_s   = acc_r + prod_ext_s;
        ovf_step_s  = add_overflow(acc_r[ACC_W-1], prod_ext_s[ACC_W-1],
                                   raw_sum_s[ACC_W-1]);
        ovf_total_s = ovf_r | ovf_step_s;
        sum_s       = raw_sum_s;
`ifdef SATURATE_EN
        // Both addends share a sign on overflow; clamp toward that sign
        if (ovf_step_s) begin
            sum_s = acc_r[ACC_W-1] ? ACC_MIN : ACC_MAX;
        end else begin
            sum_s = raw_sum_s;
        end
`else
        sum_s = raw_sum_s;
`endif
    end

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_ACC;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; clr always returns to ACC
    always_comb begin
        state_next_s = state_r;
        if (clr) begin
            state_next_s = ST_ACC;
        end else begin
            case (state_r)
                ST_ACC: begin
                    if (accept_s && last_s) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_ACC;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state_next_s = ST_ACC;
                    end else begin
                        state_next_s = ST_DONE;
                    end
                end
                default: begin
                    state_next_s = ST_ACC;
                end
            endcase
        end
    end

    // State-decoded handshake outputs; clr masks in_ready immediately
    always_comb begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        case (state_r)
            ST_ACC: begin
                in_ready_s  = !clr;
                out_valid_s = 1'b0;
            end
            ST_DONE: begin
                in_ready_s  = 1'b0;
                out_valid_s = 1'b1;
            end
            default: begin
                in_ready_s  = 1'b0;
                out_valid_s = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath
    // -----------------------------------------------------------------------

    // Accumulator, counter, sticky overflow and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r     <= ACC_ZERO;
            cnt_r     <= CNT_ZERO;
            ovf_r     <= 1'b0;
            out_sum_r <= ACC_ZERO;
            out_ovf_r <= 1'b0;
            busy_r    <= 1'b0;
        end else if (clr) begin
            // Abort: partial sum and any pending result are discarded
            acc_r     <= ACC_ZERO;
            cnt_r     <= CNT_ZERO;
            ovf_r     <= 1'b0;
            out_sum_r <= ACC_ZERO;
            out_ovf_r <= 1'b0;
            busy_r    <= 1'b0;
        end else if (accept_s) begin
            acc_r  <= sum_s;
            ovf_r  <= ovf_total_s;
            busy_r <= 1'b1;
            if (last_s) begin
                cnt_r     <= CNT_ZERO;
                out_sum_r <= sum_s;
                out_ovf_r <= ovf_total_s;
            end else begin
                cnt_r     <= cnt_r + CNT_ONE;
            end
        end else if (consume_s) begin
            // Result taken: start the next sum from zero
            acc_r  <= ACC_ZERO;
            ovf_r  <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            acc_r  <= acc_r;
            ovf_r  <= ovf_r;
            busy_r <= busy_r;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_s;
    assign bus.out_sum   = out_sum_r;
    assign bus.out_ovf   = out_ovf_r;
    assign busy          = busy_r;

endmodule

// File: tb/tb_booth_mac_acc.sv
// ---------------------------------------------------------------------------
// tb_booth_mac_acc
// Directed bench for booth_mac_acc. Three instances cover the scenarios:
//   dut_a : LEN=4,  ACC_W=40  (basic sum, backpressure, clr, idle, reset)
//   dut_b : LEN=16, ACC_W=40  (extreme negative products)
//   dut_c : LEN=4,  ACC_W=33  (signed overflow, wrap or saturate)
// ---------------------------------------------------------------------------
module tb_booth_mac_acc;

    logic clk = 1'b0;
    logic rst_n;
    logic clr_a, clr_b, clr_c;
    logic busy_a, busy_b, busy_c;

    int n_vec = 0;
    int n_err = 0;

    booth_mac_acc_if #(.PROD_W(32), .ACC_W(40)) ifa ();
    booth_mac_acc_if #(.PROD_W(32), .ACC_W(40)) ifb ();
    booth_mac_acc_if #(.PROD_W(32), .ACC_W(33)) ifc ();

    booth_mac_acc #(.PROD_W(32), .ACC_W(40), .LEN(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .clr(clr_a), .bus(ifa), .busy(busy_a)
    );
    booth_mac_acc #(.PROD_W(32), .ACC_W(40), .LEN(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .clr(clr_b), .bus(ifb), .busy(busy_b)
    );
    booth_mac_acc #(.PROD_W(32), .ACC_W(33), .LEN(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .clr(clr_c), .bus(ifc), .busy(busy_c)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One product presented to dut_a for one clock edge
    task automatic push_a(input logic signed [31:0] p);
        ifa.in_valid = 1'b1;
        ifa.in_prod  = p;
        @(posedge clk); #1;
    endtask

    // One idle cycle on dut_a
    task automatic idle_a();
        ifa.in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic push_c(input logic signed [31:0] p);
        ifc.in_valid = 1'b1;
        ifc.in_prod  = p;
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0;
        clr_a = 1'b0; clr_b = 1'b0; clr_c = 1'b0;
        ifa.in_valid = 1'b0; ifa.in_prod = 32'sd0; ifa.out_ready = 1'b1;
        ifb.in_valid = 1'b0; ifb.in_prod = 32'sd0; ifb.out_ready = 1'b1;
        ifc.in_valid = 1'b0; ifc.in_prod = 32'sd0; ifc.out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", ifa.out_valid, 64'sd0);
        chk("rst_out_sum",   ifa.out_sum,   64'sd0);
        chk("rst_out_ovf",   ifa.out_ovf,   64'sd0);
        chk("rst_busy",      busy_a,        64'sd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready",  ifa.in_ready,  64'sd1);

        // Basic sum 100 - 30 + 7 + 0 = 77, result held for backpressure
        ifa.out_ready = 1'b0;
        push_a(32'sd100);
        chk("basic_busy_first", busy_a, 64'sd1);
        chk("basic_no_valid",   ifa.out_valid, 64'sd0);
        push_a(-32'sd30);
        push_a(32'sd7);
        push_a(32'sd0);
        chk("basic_out_valid", ifa.out_valid, 64'sd1);
        chk("basic_out_sum",   ifa.out_sum,   64'sd77);
        chk("basic_out_ovf",   ifa.out_ovf,   64'sd0);
        chk("basic_busy_done", busy_a,        64'sd1);

        // Backpressure: result held, products refused
        ifa.in_valid = 1'b1;
        ifa.in_prod  = 32'sd55;
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready",  ifa.in_ready,  64'sd0);
            chk("bp_out_sum",   ifa.out_sum,   64'sd77);
            chk("bp_out_valid", ifa.out_valid, 64'sd1);
            @(posedge clk); #1;
        end
        ifa.in_valid  = 1'b0;
        ifa.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_rel_out_valid", ifa.out_valid, 64'sd0);
        chk("bp_rel_in_ready",  ifa.in_ready,  64'sd1);
        chk("bp_rel_busy",      busy_a,        64'sd0);

        // Next sum starts from zero: 1000 - 1 - 1 + 2 = 1000
        push_a(32'sd1000);
        push_a(-32'sd1);
        push_a(-32'sd1);
        push_a(32'sd2);
        chk("next_out_sum",   ifa.out_sum,   64'sd1000);
        chk("next_out_valid", ifa.out_valid, 64'sd1);
        idle_a();

        // Clear mid-sum: 5, 6, then clr with 9 presented
        push_a(32'sd5);
        push_a(32'sd6);
        ifa.in_valid = 1'b1;
        ifa.in_prod  = 32'sd9;
        clr_a = 1'b1;
        #1;
        chk("clr_in_ready", ifa.in_ready, 64'sd0);
        @(posedge clk); #1;
        clr_a = 1'b0;
        ifa.in_valid = 1'b0;
        chk("clr_busy",      busy_a,        64'sd0);
        chk("clr_out_valid", ifa.out_valid, 64'sd0);
        push_a(32'sd1);
        push_a(32'sd2);
        push_a(32'sd3);
        push_a(32'sd4);
        chk("clr_out_sum",   ifa.out_sum,   64'sd10);
        chk("clr_valid",     ifa.out_valid, 64'sd1);
        idle_a();

        // Idle gaps hold the partial sum: 3 + 4 + 5 + 6 = 18
        push_a(32'sd3);
        idle_a(); idle_a(); idle_a();
        chk("idle_busy",      busy_a,        64'sd1);
        chk("idle_out_valid", ifa.out_valid, 64'sd0);
        push_a(32'sd4);
        push_a(32'sd5);
        push_a(32'sd6);
        chk("idle_out_sum", ifa.out_sum, 64'sd18);
        idle_a();

        // Negative result: -100 - 200 + 50 - 1 = -251
        push_a(-32'sd100);
        push_a(-32'sd200);
        push_a(32'sd50);
        push_a(-32'sd1);
        chk("neg_out_sum", ifa.out_sum, -64'sd251);
        chk("neg_out_ovf", ifa.out_ovf, 64'sd0);
        idle_a();

        // Extremes: 16 x -2^30 = -2^34, fits in 40 bits
        for (int i = 0; i < 16; i++) begin
            ifb.in_valid = 1'b1;
            ifb.in_prod  = 32'shC000_0000;
            @(posedge clk); #1;
        end
        ifb.in_valid = 1'b0;
        chk("ext_out_valid", ifb.out_valid, 64'sd1);
        chk("ext_out_sum",   ifb.out_sum,   -64'sd17179869184);
        chk("ext_out_ovf",   ifb.out_ovf,   64'sd0);
        @(posedge clk); #1;
        chk("ext_consumed",  ifb.out_valid, 64'sd0);

        // Overflow in 33 bits: 4 x 0x7FFFFFFF, result held
        ifc.out_ready = 1'b0;
        push_c(32'sh7FFF_FFFF);
        push_c(32'sh7FFF_FFFF);
        push_c(32'sh7FFF_FFFF);
        push_c(32'sh7FFF_FFFF);
        ifc.in_valid = 1'b0;
        chk("ovf_out_valid", ifc.out_valid, 64'sd1);
        chk("ovf_out_ovf",   ifc.out_ovf,   64'sd1);
`ifdef SATURATE_EN
        chk("ovf_out_sum",   ifc.out_sum,   64'sd4294967295);
`else
        chk("ovf_out_sum",   ifc.out_sum,   -64'sd4);
`endif

        // Hold a result in dut_a too: 10 + 20 + 30 + 40 = 100
        ifa.out_ready = 1'b0;
        push_a(32'sd10);
        push_a(32'sd20);
        push_a(32'sd30);
        push_a(32'sd40);
        ifa.in_valid = 1'b0;
        chk("pre_rst_out_sum", ifa.out_sum, 64'sd100);

        // Asynchronous reset mid-cycle while both results are held
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_a_out_valid", ifa.out_valid, 64'sd0);
        chk("arst_a_out_sum",   ifa.out_sum,   64'sd0);
        chk("arst_a_busy",      busy_a,        64'sd0);
        chk("arst_c_out_valid", ifc.out_valid, 64'sd0);
        chk("arst_c_out_sum",   ifc.out_sum,   64'sd0);
        chk("arst_c_out_ovf",   ifc.out_ovf,   64'sd0);
        chk("arst_c_busy",      busy_c,        64'sd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ifa.out_ready = 1'b1;
        ifc.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("arst_a_in_ready", ifa.in_ready, 64'sd1);
        chk("arst_c_in_ready", ifc.in_ready, 64'sd1);

        // Fresh sum after reset: 2 + 2 + 2 + 2 = 8
        push_a(32'sd2);
        push_a(32'sd2);
        push_a(32'sd2);
        push_a(32'sd2);
        chk("post_rst_out_sum", ifa.out_sum, 64'sd8);
        idle_a();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
